// File: rtl/decode_issue_ctrl_pkg.sv
// Shared types for the decode/issue controller: instruction word, decoded
// control word, immediate encodings, issue FSM states and the ID/EX payload.
package decode_issue_ctrl_pkg;

   localparam int unsigned ILEN      = 32;
   localparam int unsigned PC_W      = 32;
   localparam int unsigned IMM_W     = 32;
   localparam int unsigned REG_IDX_W = 5;

   typedef logic [ILEN-1:0] instruction_type;

   typedef enum logic [2:0] {
      I_TYPE = 3'd0,
      U_TYPE = 3'd1,
      S_TYPE = 3'd2,
      B_TYPE = 3'd3,
      R_TYPE = 3'd4
   } encoding_type;

   typedef struct packed {
      encoding_type encoding;
      logic         mem_read;
      logic         mem_write;
      logic         reg_write;
   } control_type;

   typedef struct packed {
      instruction_type      instruction;
      logic [PC_W-1:0]      pc;
      control_type          control;
      logic [IMM_W-1:0]     imm;
      logic [REG_IDX_W-1:0] rs1;
      logic [REG_IDX_W-1:0] rs2;
      logic [REG_IDX_W-1:0] rd;
   } id_ex_type;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_type;

   // Only R, S and B formats carry a real rs2 operand.
   function automatic logic uses_rs2(encoding_type enc);
      logic used;
      case (enc)
         R_TYPE, S_TYPE, B_TYPE: used = 1'b1;
         default:                used = 1'b0;
      endcase
      return used;
   endfunction

endpackage

// File: rtl/decode_issue_ctrl_imm_gen.sv
// Immediate generator: sign-extended immediate for the given encoding.
// Only instruction bits [31:7] carry immediate fields, so the opcode is not an input.
module decode_issue_ctrl_imm_gen
   import decode_issue_ctrl_pkg::*;
(
   input  logic [ILEN-1:7]  instruction,
   input  encoding_type     encoding,
   output logic [IMM_W-1:0] imm
);

   // Select and sign-extend the immediate fields for the format.
   always_comb begin
      imm = '0;
      case (encoding)
         I_TYPE: imm = {{20{instruction[31]}}, instruction[31:20]};
         S_TYPE: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
         B_TYPE: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                        instruction[30:25], instruction[11:8], 1'b0};
         U_TYPE: imm = {instruction[31:12], 12'h000};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_issue_ctrl.sv
// Decode-to-execute issue controller: one-entry ID/EX register with a
// valid/ready handshake, load-use bubble insertion and branch flush.
// Build option DECODE_ISSUE_PERF_EN adds bubble_count / flush_count outputs.
module decode_issue_ctrl
   import decode_issue_ctrl_pkg::*;
#(
   parameter int unsigned XLEN = 32
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  instruction_type      in_instruction,
   input  logic [XLEN-1:0]      in_pc,
   input  control_type          in_control,
   output logic                 out_valid,
   input  logic                 out_ready,
   output instruction_type      out_instruction,
   output logic [XLEN-1:0]      out_pc,
   output control_type          out_control,
   output logic [IMM_W-1:0]     out_imm,
   output logic [REG_IDX_W-1:0] out_rs1,
   output logic [REG_IDX_W-1:0] out_rs2,
`ifdef DECODE_ISSUE_PERF_EN
   output logic [31:0]          bubble_count,
   output logic [31:0]          flush_count,
`endif
   output logic [REG_IDX_W-1:0] out_rd
);

   state_type        state;
   state_type        state_next;
   id_ex_type        id_ex;
   logic             capture;
   logic             hazard;
   logic [IMM_W-1:0] imm;

   decode_issue_ctrl_imm_gen u_imm_gen (
      .instruction (in_instruction[ILEN-1:7]),
      .encoding    (in_control.encoding),
      .imm         (imm)
   );

   // Load in ID/EX whose destination feeds the incoming instruction.
   always_comb begin
      hazard = 1'b0;
      if (state == FULL && id_ex.control.mem_read && id_ex.rd != '0) begin
         hazard = (id_ex.rd == in_instruction[19:15]) ||
                  ((id_ex.rd == in_instruction[24:20]) && uses_rs2(in_control.encoding));
      end
   end

   assign in_ready = !flush && !hazard && (state == EMPTY || out_ready);

   // Next state: flush beats capture, capture beats drain, otherwise hold.
   always_comb begin
      state_next = state;
      capture    = 1'b0;
      if (flush) begin
         state_next = EMPTY;
      end else if (in_valid && in_ready) begin
         state_next = FULL;
         capture    = 1'b1;
      end else if (state == FULL && out_ready) begin
         state_next = EMPTY;
      end
   end

   // Issue state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= EMPTY;
      else       state <= state_next;
   end

   // ID/EX payload; only written on an accepted instruction, so a flush clears valid only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         id_ex <= '0;
      end else if (capture) begin
         id_ex.instruction <= in_instruction;
         id_ex.pc          <= in_pc;
         id_ex.control     <= in_control;
         id_ex.imm         <= imm;
         id_ex.rs1         <= in_instruction[19:15];
         id_ex.rs2         <= in_instruction[24:20];
         id_ex.rd          <= in_instruction[11:7];
      end
   end

   assign out_valid       = (state == FULL);
   assign out_instruction = id_ex.instruction;
   assign out_pc          = id_ex.pc;
   assign out_control     = id_ex.control;
   assign out_imm         = id_ex.imm;
   assign out_rs1         = id_ex.rs1;
   assign out_rs2         = id_ex.rs2;
   assign out_rd          = id_ex.rd;

`ifdef DECODE_ISSUE_PERF_EN
   // Free-running wrap-around counters of stalled-issue and flushed cycles.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bubble_count <= '0;
         flush_count  <= '0;
      end else begin
         if (hazard && out_ready)               bubble_count <= bubble_count + 32'd1;
         if (flush && (out_valid || in_valid))  flush_count  <= flush_count + 32'd1;
      end
   end
`endif

endmodule
